// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the writeback/MDU producers, the arbiter and the regfile/commit sinks.
interface wb_port_arbiter_if #(
  parameter int XLEN = 64
);
  logic            pipe_valid;
  logic            pipe_ready;
  logic [XLEN-1:0] pipe_pc;
  logic [31:0]     pipe_instr;
  logic            pipe_wen;
  logic [4:0]      pipe_dst;
  logic [XLEN-1:0] pipe_wdata;

  logic            mdu_valid;
  logic            mdu_ready;
  logic [XLEN-1:0] mdu_pc;
  logic [31:0]     mdu_instr;
  logic            mdu_wen;
  logic [4:0]      mdu_dst;
  logic [XLEN-1:0] mdu_wdata;

  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_instr;
  logic [63:0]     commit_cnt;

  // Arbiter side: consumes both request streams, drives readies and the write/commit port.
  modport slave (
    input  pipe_valid, pipe_pc, pipe_instr, pipe_wen, pipe_dst, pipe_wdata,
    input  mdu_valid, mdu_pc, mdu_instr, mdu_wen, mdu_dst, mdu_wdata,
    output pipe_ready, mdu_ready,
    output rf_we, rf_waddr, rf_wdata,
    output commit_valid, commit_pc, commit_instr, commit_cnt
  );

  modport master (
    output pipe_valid, pipe_pc, pipe_instr, pipe_wen, pipe_dst, pipe_wdata,
    output mdu_valid, mdu_pc, mdu_instr, mdu_wen, mdu_dst, mdu_wdata,
    input  pipe_ready, mdu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  commit_valid, commit_pc, commit_instr, commit_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port and commit stream between pipeline writeback and the MDU,
// letting the pipe win at most MAX_PIPE_BURST contested cycles in a row.
module wb_port_arbiter #(
  parameter int MAX_PIPE_BURST = 4,
  parameter int XLEN           = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  wb_port_arbiter_if.slave        bus
);

  // A zero burst limit still needs a one-bit counter; it simply never leaves zero.
  localparam int BW = (MAX_PIPE_BURST > 0) ? $clog2(MAX_PIPE_BURST + 1) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_PIPE_BURST);

  logic [BW-1:0]   burst_q, burst_d;
  logic            pipe_gnt_s, mdu_gnt_s, accept_s;
  logic            sel_wen_s;
  logic [4:0]      sel_dst_s;
  logic [XLEN-1:0] sel_pc_s, sel_wdata_s;
  logic [31:0]     sel_instr_s;

  logic            rf_we_q, commit_valid_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q, commit_pc_q;
  logic [31:0]     commit_instr_q;
  logic [63:0]     commit_cnt_q;

  // Grant decision and burst counter next state.
  always_comb begin
    pipe_gnt_s = 1'b0;
    mdu_gnt_s  = 1'b0;
    burst_d    = burst_q;
    if (reset) begin
      burst_d = burst_q;
    end else if (bus.pipe_valid && bus.mdu_valid) begin
      if (burst_q == BURST_MAX) begin
        mdu_gnt_s = 1'b1;
        burst_d   = '0;
      end else begin
        pipe_gnt_s = 1'b1;
        burst_d    = burst_q + BW'(1);
      end
    end else if (bus.pipe_valid) begin
      pipe_gnt_s = 1'b1;
    end else if (bus.mdu_valid) begin
      mdu_gnt_s = 1'b1;
      burst_d   = '0;
    end else begin
      burst_d = burst_q;
    end
  end

  assign accept_s      = pipe_gnt_s | mdu_gnt_s;
  assign bus.pipe_ready = pipe_gnt_s;
  assign bus.mdu_ready  = mdu_gnt_s;

  // Select the granted entry's payload.
  always_comb begin
    sel_wen_s   = bus.mdu_wen;
    sel_dst_s   = bus.mdu_dst;
    sel_pc_s    = bus.mdu_pc;
    sel_wdata_s = bus.mdu_wdata;
    sel_instr_s = bus.mdu_instr;
    if (pipe_gnt_s) begin
      sel_wen_s   = bus.pipe_wen;
      sel_dst_s   = bus.pipe_dst;
      sel_pc_s    = bus.pipe_pc;
      sel_wdata_s = bus.pipe_wdata;
      sel_instr_s = bus.pipe_instr;
    end else begin
      sel_wen_s   = bus.mdu_wen;
      sel_dst_s   = bus.mdu_dst;
      sel_pc_s    = bus.mdu_pc;
      sel_wdata_s = bus.mdu_wdata;
      sel_instr_s = bus.mdu_instr;
    end
  end

  // Registered write/commit port, burst counter and commit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_q        <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= 5'd0;
      rf_wdata_q     <= '0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_instr_q <= 32'd0;
      commit_cnt_q   <= 64'd0;
    end else begin
      burst_q <= burst_d;
      if (accept_s) begin
        // x0 is never written, but the instruction still retires.
        rf_we_q        <= sel_wen_s && (sel_dst_s != 5'd0);
        rf_waddr_q     <= sel_dst_s;
        rf_wdata_q     <= sel_wdata_s;
        commit_valid_q <= 1'b1;
        commit_pc_q    <= sel_pc_s;
        commit_instr_q <= sel_instr_s;
        commit_cnt_q   <= commit_cnt_q + 64'd1;
      end else begin
        rf_we_q        <= 1'b0;
        commit_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_pc    = commit_pc_q;
  assign bus.commit_instr = commit_instr_q;
  assign bus.commit_cnt   = commit_cnt_q;

endmodule
